// File: rtl/aes_pkg.sv
// Shared AES definitions for the S-box scheduler slice: byte counts, the
// scheduler FSM encoding, byte extraction and the team S-box function.
package aes_pkg;

    localparam int unsigned AES_STATE_BYTES = 16;
    localparam int unsigned AES_WORD_BYTES  = 4;

    typedef enum logic [1:0] {
        IDLE,
        ST_RUN,
        KW_RUN,
        WAIT
    } sched_state_t;

    // Byte k of a 128-bit state, byte 0 in the most significant position
    function automatic logic [7:0] get_byte(input logic [127:0] v, input int unsigned k);
        return 8'(v >> (8 * (AES_STATE_BYTES - 1 - k)));
    endfunction

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = '0;
        aa = a;
        bb = b;
        for (int unsigned i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        logic [7:0] e;
        r  = 8'h01;
        sq = a;
        e  = 8'd254;
        for (int unsigned i = 0; i < 8; i++) begin
            if (e[0]) r = gf_mul(r, sq);
            sq = gf_mul(sq, sq);
            e  = e >> 1;
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // AES forward S-box: inverse followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

endpackage

// File: rtl/sbox_bank.sv
// Bank of NUM_SBOX parallel S-box lanes, purely combinational.
// Lane 0 occupies the most significant byte of each lane vector.
module sbox_bank
    import aes_pkg::*;
#(
    parameter int unsigned NUM_SBOX = 4
) (
    input  logic [NUM_SBOX*8-1:0] lanes_in,
    output logic [NUM_SBOX*8-1:0] lanes_out
);

    for (genvar j = 0; j < NUM_SBOX; j++) begin : g_lane
        assign lanes_out[NUM_SBOX*8-1-8*j -: 8] = sbox(lanes_in[NUM_SBOX*8-1-8*j -: 8]);
    end

endmodule

// File: rtl/sbox_sched.sv
// Arbitrates SubBytes (128-bit state) and SubWord (32-bit key word) jobs onto
// a shared bank of NUM_SBOX S-box lanes. Grants are only issued in IDLE; the
// done cycle is itself IDLE so back-to-back jobs have no dead cycle.
// Build option SBOX_SCHED_PIPE_EN: registers the bank outputs, adding one
// WAIT cycle per job before the done pulse.
module sbox_sched
    import aes_pkg::*;
#(
    parameter int unsigned NUM_SBOX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st_req,
    input  logic [127:0] st_in,
    output logic         st_gnt,
    output logic         st_done,
    output logic [127:0] st_out,
    input  logic         kw_req,
    input  logic [31:0]  kw_in,
    output logic         kw_gnt,
    output logic         kw_done,
    output logic [31:0]  kw_out,
    output logic         busy
);

    localparam int unsigned BEATS = AES_STATE_BYTES / NUM_SBOX;
    localparam int unsigned LW    = NUM_SBOX * 8;
    localparam int unsigned KW_W  = AES_WORD_BYTES * 8;

`ifdef SBOX_SCHED_PIPE_EN
    localparam sched_state_t AFTER_RUN = WAIT;
`else
    localparam sched_state_t AFTER_RUN = IDLE;
`endif

    sched_state_t   state;
    logic [1:0]     beat;
    logic           rr_kw;
    logic [127:0]   st_reg;
    logic [31:0]    kw_reg;
    logic [127:0]   st_shadow;
    logic [127:0]   st_next_shadow;
    logic [LW-1:0]  lanes_in;
    logic [LW-1:0]  lanes_out;

    // Write-back source: the beat whose bank results land in the shadow now
    logic           cur_en;
    logic           cur_st;
    logic           wr_en;
    logic           wr_st;
    logic           wr_last;
    logic [1:0]     wr_beat;
    logic [LW-1:0]  wr_data;

    assign busy   = (state != IDLE);
    assign cur_en = (state == ST_RUN) || (state == KW_RUN);
    assign cur_st = (state == ST_RUN);

    // Grants are decided combinationally in IDLE so the input is captured on this edge
    always_comb begin
        st_gnt = 1'b0;
        kw_gnt = 1'b0;
        if (state == IDLE) begin
            if (kw_req && (!st_req || rr_kw)) kw_gnt = 1'b1;
            else if (st_req)                  st_gnt = 1'b1;
        end
    end

    // Present the current beat's bytes to the bank; unused lanes carry 0x00
    always_comb begin
        lanes_in = '0;
        if (state == ST_RUN) begin
            for (int unsigned j = 0; j < NUM_SBOX; j++) begin
                lanes_in = lanes_in
                         | (LW'(get_byte(st_reg, 32'(beat) * NUM_SBOX + j)) << (LW - 8 - 8 * j));
            end
        end else if (state == KW_RUN) begin
            lanes_in = LW'(kw_reg) << (LW - KW_W);
        end
    end

    sbox_bank #(.NUM_SBOX(NUM_SBOX)) u_bank (
        .lanes_in  (lanes_in),
        .lanes_out (lanes_out)
    );

`ifdef SBOX_SCHED_PIPE_EN
    // Bank results are registered, so write-back trails the lookup by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_st   <= 1'b0;
            wr_beat <= '0;
            wr_data <= '0;
        end else begin
            wr_en   <= cur_en;
            wr_st   <= cur_st;
            wr_beat <= beat;
            wr_data <= lanes_out;
        end
    end
    assign wr_last = (state == WAIT);
`else
    assign wr_en   = cur_en;
    assign wr_st   = cur_st;
    assign wr_beat = beat;
    assign wr_data = lanes_out;
    assign wr_last = (state == KW_RUN) || ((state == ST_RUN) && (beat == 2'(BEATS - 1)));
`endif

    // Merge the written beat into the state shadow so done can publish the full result
    always_comb begin
        st_next_shadow = st_shadow;
        if (wr_en && wr_st) begin
            st_next_shadow = (st_shadow
                              & ~(128'({LW{1'b1}}) << (LW * (BEATS - 1 - 32'(wr_beat)))))
                           | (128'(wr_data) << (LW * (BEATS - 1 - 32'(wr_beat))));
        end
    end

    // Scheduler FSM with input latches, shadow, registered done pulses and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            beat      <= '0;
            rr_kw     <= 1'b1;
            st_reg    <= '0;
            kw_reg    <= '0;
            st_shadow <= '0;
            st_out    <= '0;
            kw_out    <= '0;
            st_done   <= 1'b0;
            kw_done   <= 1'b0;
        end else begin
            st_done   <= 1'b0;
            kw_done   <= 1'b0;
            st_shadow <= st_next_shadow;
            if (wr_last) begin
                if (wr_st) begin
                    st_done <= 1'b1;
                    st_out  <= st_next_shadow;
                end else begin
                    kw_done <= 1'b1;
                    kw_out  <= wr_data[LW-1 -: KW_W];
                end
            end
            case (state)
                IDLE: begin
                    if (st_gnt) begin
                        st_reg <= st_in;
                        beat   <= '0;
                        rr_kw  <= 1'b1;
                        state  <= ST_RUN;
                    end else if (kw_gnt) begin
                        kw_reg <= kw_in;
                        rr_kw  <= 1'b0;
                        state  <= KW_RUN;
                    end
                end
                ST_RUN: begin
                    if (beat == 2'(BEATS - 1)) begin
                        beat  <= '0;
                        state <= AFTER_RUN;
                    end else begin
                        beat <= beat + 2'd1;
                    end
                end
                KW_RUN:  state <= AFTER_RUN;
                WAIT:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
